exe_div_ctrl: RTL and testbench

Issue-side controller for the pipelined divide unit. Tracks every divide in flight between the issue stage and writeback, and stalls dependent or excess divide issues. On a taken branch it kills speculative divides so their late results never reach the register file. Sits between IX (issue) and the divider/WB path; its writeback-enable output gates the divider's result valid.

---
 rtl/exe_div_ctrl_if.sv | 39 +++
 rtl/exe_div_ctrl.sv | 89 ++++++++
 tb/tb_exe_div_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exe_div_ctrl_if.sv
// Interface between IX/WB and the divide issue controller.
// The IX/WB side uses the master modport and the controller uses the slave modport.
interface exe_div_ctrl_if #(
  parameter int unsigned MAX_INFLIGHT = 8
);
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  logic          ix_div_req;
  logic [4:0]    ix_div_rd;
  logic [4:0]    ix_rs1_idx;
  logic [4:0]    ix_rs2_idx;
  logic          ix_rs1_used;
  logic          ix_rs2_used;
  logic          ix_div_spec;
  logic          wb_do_branch;
  logic          wb_branch_retire;
  logic          div_valid_in;

  logic          div_grant;
  logic          div_raw_stall;
  logic          div_full;
  logic          div_wb_en;
  logic          div_wb_busy_next;
  logic [CW-1:0] div_inflight_cnt;

  modport master (
    output ix_div_req, ix_div_rd, ix_rs1_idx, ix_rs2_idx, ix_rs1_used, ix_rs2_used,
           ix_div_spec, wb_do_branch, wb_branch_retire, div_valid_in,
    input  div_grant, div_raw_stall, div_full, div_wb_en, div_wb_busy_next,
           div_inflight_cnt
  );

  modport slave (
    input  ix_div_req, ix_div_rd, ix_rs1_idx, ix_rs2_idx, ix_rs1_used, ix_rs2_used,
           ix_div_spec, wb_do_branch, wb_branch_retire, div_valid_in,
    output div_grant, div_raw_stall, div_full, div_wb_en, div_wb_busy_next,
           div_inflight_cnt
  );
endinterface

// File: rtl/exe_div_ctrl.sv
// Divide issue controller. It tracks in-flight divides in a shift pipe that mirrors the divider latency,
// stalls RAW and over-capacity issues, and kills speculative divides when a branch is taken.
module exe_div_ctrl #(
  parameter int unsigned LATENCY      = 18,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  exe_div_ctrl_if.slave      bus
);
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  logic [LATENCY-1:0]      v_q, v_d;
  logic [LATENCY-1:0]      s_q, s_d;
  logic [LATENCY-1:0][4:0] rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic        tail_live;
  logic        raw;
  logic        full;
  logic        grant;
  logic        kill;
  int unsigned kill_n;
  int          cnt_calc;

  always_comb begin
    v_d      = '0;
    s_d      = '0;
    rd_d     = '0;
    raw      = 1'b0;
    kill     = 1'b0;
    kill_n   = 0;
    cnt_calc = 0;

    tail_live = v_q[LATENCY-1];

    for (int unsigned k = 0; k < LATENCY; k++) begin
      if (v_q[k] && rd_q[k] != 5'd0 &&
          ((bus.ix_rs1_used && rd_q[k] == bus.ix_rs1_idx) ||
           (bus.ix_rs2_used && rd_q[k] == bus.ix_rs2_idx)))
        raw = 1'b1;
    end

    full  = (cnt_q == CW'(MAX_INFLIGHT)) && !tail_live;
    grant = !rst && bus.ix_div_req && !raw && !full && !bus.wb_do_branch;

    v_d[0]  = grant;
    s_d[0]  = grant && bus.ix_div_spec;
    rd_d[0] = bus.ix_div_rd;

    // The flush looks at the spec bits before this edge's retire clear. The tail is never
    // killed: it commits this cycle.
    for (int unsigned k = 1; k < LATENCY; k++) begin
      kill = bus.wb_do_branch && s_q[k-1];
      if (v_q[k-1] && kill)
        kill_n = kill_n + 1;
      v_d[k]  = v_q[k-1] && !kill;
      s_d[k]  = v_q[k-1] && !kill && s_q[k-1] && !bus.wb_branch_retire;
      rd_d[k] = rd_q[k-1];
    end

    cnt_calc = int'(cnt_q) + int'(grant) - int'(tail_live) - int'(kill_n);
    cnt_d    = CW'(cnt_calc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      s_q   <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      s_q   <= s_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.div_grant        = grant;
  assign bus.div_raw_stall    = raw;
  assign bus.div_full         = full;
  assign bus.div_wb_en        = bus.div_valid_in && tail_live;
  assign bus.div_wb_busy_next = v_q[LATENCY-2];
  assign bus.div_inflight_cnt = cnt_q;

  cnt_range_a: assert property (@(posedge clk) disable iff (rst)
    (cnt_calc >= 0) && (cnt_calc <= int'(MAX_INFLIGHT)));
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Scoreboard bench for exe_div_ctrl. The reference model keeps a list of divides with their issue cycles.
// Expected per-cycle outputs are queued and then compared by a negedge monitor.
module tb_exe_div_ctrl;
  localparam int unsigned L      = 18;
  localparam int unsigned MI     = 8;
  localparam int unsigned CW     = $clog2(MI + 1);
  localparam int unsigned NCYC   = 3000;
  localparam int unsigned RST_AT = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_div_ctrl_if #(.MAX_INFLIGHT(MI)) bus ();

  exe_div_ctrl #(.LATENCY(L), .MAX_INFLIGHT(MI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int unsigned issue;
    logic [4:0]  rd;
    bit          spec;
  } op_t;

  typedef struct {
    int unsigned cyc;
    bit          grant;
    bit          raw;
    bit          full;
    bit          wb_en;
    bit          busy;
    int unsigned cnt;
  } exp_t;

  op_t         ops[$];
  op_t         keep[$];
  int unsigned grants[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input int unsigned cyc,
                       input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("div_grant",        e.cyc, int'(bus.div_grant),        int'(e.grant));
      check("div_raw_stall",    e.cyc, int'(bus.div_raw_stall),    int'(e.raw));
      check("div_full",         e.cyc, int'(bus.div_full),         int'(e.full));
      check("div_wb_en",        e.cyc, int'(bus.div_wb_en),        int'(e.wb_en));
      check("div_wb_busy_next", e.cyc, int'(bus.div_wb_busy_next), int'(e.busy));
      check("div_inflight_cnt", e.cyc, int'(bus.div_inflight_cnt), e.cnt);
    end
  end

  initial begin
    bus.ix_div_req       = 1'b0;
    bus.ix_div_rd        = '0;
    bus.ix_rs1_idx       = '0;
    bus.ix_rs2_idx       = '0;
    bus.ix_rs1_used      = 1'b0;
    bus.ix_rs2_used      = 1'b0;
    bus.ix_div_spec      = 1'b0;
    bus.wb_do_branch     = 1'b0;
    bus.wb_branch_retire = 1'b0;
    bus.div_valid_in     = 1'b0;

    for (int unsigned n = 0; n < NCYC; n++) begin
      exp_t        e;
      bit          tail;
      int unsigned mode;
      @(posedge clk);
      #1;
      rst = (n < 2) || (n >= RST_AT && n < RST_AT + 2);

      mode = (n < 60) ? 3 : (n / 250) % 3;
      if (mode == 3) begin
        // Directed burst: always request, no hazards, and no branches, so the pipe fills to capacity.
        bus.ix_div_req       = 1'b1;
        bus.ix_div_spec      = 1'b0;
        bus.ix_rs1_used      = 1'b0;
        bus.ix_rs2_used      = 1'b0;
        bus.wb_do_branch     = 1'b0;
        bus.wb_branch_retire = 1'b0;
      end else begin
        bus.ix_div_req       = ($urandom_range(0, 99) < ((mode == 1) ? 90 : 45));
        bus.ix_div_spec      = $urandom_range(0, 1);
        bus.ix_rs1_used      = $urandom_range(0, 1);
        bus.ix_rs2_used      = $urandom_range(0, 1);
        bus.wb_do_branch     = ($urandom_range(0, 99) < ((mode == 2) ? 10 : 2));
        bus.wb_branch_retire = ($urandom_range(0, 99) < 6);
        if (bus.wb_branch_retire)
          bus.ix_div_spec = 1'b0;
      end
      bus.ix_div_rd  = 5'($urandom_range(0, 7));
      bus.ix_rs1_idx = 5'($urandom_range(0, 7));
      bus.ix_rs2_idx = 5'($urandom_range(0, 7));

      // The divider returns a result L cycles after every grant, including grants whose op was killed.
      bus.div_valid_in = 1'b0;
      while (grants.size() > 0 && grants[0] + L < n)
        void'(grants.pop_front());
      foreach (grants[i])
        if (grants[i] + L == n)
          bus.div_valid_in = 1'b1;

      e.cyc = n;
      if (rst) begin
        ops.delete();
        e.grant = 0; e.raw = 0; e.full = 0; e.wb_en = 0; e.busy = 0; e.cnt = 0;
      end else begin
        tail   = 0;
        e.busy = 0;
        e.raw  = 0;
        e.cnt  = ops.size();
        foreach (ops[i]) begin
          if (ops[i].issue + L == n)     tail   = 1;
          if (ops[i].issue + L - 1 == n) e.busy = 1;
          if (ops[i].rd != 0 &&
              ((bus.ix_rs1_used && ops[i].rd == bus.ix_rs1_idx) ||
               (bus.ix_rs2_used && ops[i].rd == bus.ix_rs2_idx)))
            e.raw = 1;
        end
        e.full  = (e.cnt == MI) && !tail;
        e.grant = bus.ix_div_req && !e.raw && !e.full && !bus.wb_do_branch;
        e.wb_en = bus.div_valid_in && tail;

        keep.delete();
        foreach (ops[i]) begin
          if (ops[i].issue + L == n) continue;
          if (bus.wb_do_branch && ops[i].spec) continue;
          keep.push_back(ops[i]);
        end
        ops = keep;
        if (bus.wb_branch_retire)
          foreach (ops[i]) ops[i].spec = 0;
        if (e.grant) begin
          ops.push_back('{issue: n, rd: bus.ix_div_rd, spec: bus.ix_div_spec});
          grants.push_back(n);
        end
      end
      exp_q.push_back(e);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
